// File: rtl/gpu_cmd_queue_if.sv
// gpu_cmd_queue_if - bundle of the APB slave port and the command stream
// port of gpu_cmd_queue.
//   master : APB requester plus command consumer (drives pSel/pEnable/...,
//            cmd_ready_i)
//   slave  : the command queue (drives pReady/pDataRead/pSlvErr, the FIFO
//            head fields and count_o)
// The parameters must match the ones of the gpu_cmd_queue instance.
interface gpu_cmd_queue_if #(
  parameter int WIDTH_BITS   = 10,
  parameter int HEIGHT_BITS  = 9,
  parameter int CHANNEL_BITS = 8,
  parameter int DEPTH        = 8
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [31:0]             pAddr_i;
  logic [31:0]             pDataWrite_i;
  logic                    pSel_i;
  logic                    pEnable_i;
  logic                    pWrite_i;
  logic                    pReady_o;
  logic [31:0]             pDataRead_o;
  logic                    pSlvErr_o;

  logic                    cmd_valid_o;
  logic                    cmd_ready_i;
  logic [3:0]              opcode_o;
  logic [WIDTH_BITS-1:0]   x1_o;
  logic [WIDTH_BITS-1:0]   x2_o;
  logic [HEIGHT_BITS-1:0]  y1_o;
  logic [HEIGHT_BITS-1:0]  y2_o;
  logic [CHANNEL_BITS-1:0] r_o;
  logic [CHANNEL_BITS-1:0] g_o;
  logic [CHANNEL_BITS-1:0] b_o;
  logic [CW-1:0]           count_o;

  modport master (
    output pAddr_i, pDataWrite_i, pSel_i, pEnable_i, pWrite_i, cmd_ready_i,
    input  pReady_o, pDataRead_o, pSlvErr_o, cmd_valid_o, opcode_o,
           x1_o, x2_o, y1_o, y2_o, r_o, g_o, b_o, count_o
  );

  modport slave (
    input  pAddr_i, pDataWrite_i, pSel_i, pEnable_i, pWrite_i, cmd_ready_i,
    output pReady_o, pDataRead_o, pSlvErr_o, cmd_valid_o, opcode_o,
           x1_o, x2_o, y1_o, y2_o, r_o, g_o, b_o, count_o
  );
endinterface

// File: rtl/gpu_cmd_queue.sv
// gpu_cmd_queue - APB front-end that assembles multi-word draw commands in
// staging registers and queues them in a DEPTH-entry first-word-fall-through
// FIFO drained by the rasteriser over valid/ready.
// Ports:
//   clk  : clock
//   rst  : asynchronous active-high reset
//   bus  : gpu_cmd_queue_if.slave - APB slave (pAddr_i, pDataWrite_i, pSel_i,
//          pEnable_i, pWrite_i, pReady_o, pDataRead_o, pSlvErr_o) and command
//          stream (cmd_valid_o, cmd_ready_i, opcode/x1/y1/x2/y2/r/g/b, count_o)
// Register map (offset = pAddr_i[7:0]):
//   0x00 W0 RW, 0x04 W1 RW, 0x08 W2 RW, 0x0C COMMIT WO,
//   0x10 STATUS RO, 0x14 CTRL WO (bit0 flush, bit1 clear overflow)
module gpu_cmd_queue #(
  parameter int WIDTH_BITS    = 10,
  parameter int HEIGHT_BITS   = 9,
  parameter int CHANNEL_BITS  = 8,
  parameter int DEPTH         = 8,
  parameter int STALL_ON_FULL = 1
) (
  input logic           clk,
  input logic           rst,
  gpu_cmd_queue_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [7:0] OFF_W0     = 8'h00;
  localparam logic [7:0] OFF_W1     = 8'h04;
  localparam logic [7:0] OFF_W2     = 8'h08;
  localparam logic [7:0] OFF_COMMIT = 8'h0C;
  localparam logic [7:0] OFF_STATUS = 8'h10;
  localparam logic [7:0] OFF_CTRL   = 8'h14;

  typedef struct packed {
    logic [3:0]              opcode;
    logic [WIDTH_BITS-1:0]   x1;
    logic [HEIGHT_BITS-1:0]  y1;
    logic [WIDTH_BITS-1:0]   x2;
    logic [HEIGHT_BITS-1:0]  y2;
    logic [CHANNEL_BITS-1:0] r;
    logic [CHANNEL_BITS-1:0] g;
    logic [CHANNEL_BITS-1:0] b;
  } cmd_t;

  // staging registers
  logic [3:0]              opcode_q;
  logic [WIDTH_BITS-1:0]   x1_q, x2_q;
  logic [HEIGHT_BITS-1:0]  y1_q, y2_q;
  logic [CHANNEL_BITS-1:0] r_q, g_q, b_q;
  logic                    ovf_q;

  // FIFO
  cmd_t          mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count_q;
  cmd_t          head;
  cmd_t          stage;

  logic [7:0]  off;
  logic        access;
  logic        hit_w0, hit_w1, hit_w2, hit_commit, hit_status, hit_ctrl, mapped;
  logic        err;
  logic        full, empty;
  logic        stall;
  logic        complete;
  logic        wr_en;
  logic        push, drop, pop, flush, ovf_clr;
  logic [31:0] rdata;

  assign off    = bus.pAddr_i[7:0];
  assign access = bus.pSel_i & bus.pEnable_i;

  assign hit_w0     = (off == OFF_W0);
  assign hit_w1     = (off == OFF_W1);
  assign hit_w2     = (off == OFF_W2);
  assign hit_commit = (off == OFF_COMMIT);
  assign hit_status = (off == OFF_STATUS);
  assign hit_ctrl   = (off == OFF_CTRL);
  assign mapped     = hit_w0 | hit_w1 | hit_w2 | hit_commit | hit_status | hit_ctrl;

  assign err = access & (~mapped | (hit_status & bus.pWrite_i) | (hit_ctrl & ~bus.pWrite_i));

  // full/empty come from the registered count only, so a pop in the same
  // cycle never admits a push and APB inputs never reach the command outputs
  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);

  assign stall    = (STALL_ON_FULL != 0) && access && bus.pWrite_i && hit_commit && full;
  assign complete = access & ~stall;
  assign wr_en    = complete & bus.pWrite_i & ~err;

  assign push    = wr_en & hit_commit & ~full;
  // only reachable in drop mode: in stall mode a full COMMIT never completes
  assign drop    = wr_en & hit_commit & full;
  assign flush   = wr_en & hit_ctrl & bus.pDataWrite_i[0];
  assign ovf_clr = wr_en & hit_ctrl & bus.pDataWrite_i[1];
  assign pop     = ~empty & bus.cmd_ready_i;

  assign stage = '{opcode: opcode_q, x1: x1_q, y1: y1_q, x2: x2_q, y2: y2_q,
                   r: r_q, g: g_q, b: b_q};

  always_comb begin
    rdata = '0;
    if (access && !bus.pWrite_i && !err) begin
      case (off)
        OFF_W0: begin
          rdata[31:28]              = opcode_q;
          rdata[HEIGHT_BITS+15:16]  = y1_q;
          rdata[WIDTH_BITS-1:0]     = x1_q;
        end
        OFF_W1: begin
          rdata[HEIGHT_BITS+15:16]  = y2_q;
          rdata[WIDTH_BITS-1:0]     = x2_q;
        end
        OFF_W2: begin
          rdata[CHANNEL_BITS+15:16] = b_q;
          rdata[CHANNEL_BITS+7:8]   = g_q;
          rdata[CHANNEL_BITS-1:0]   = r_q;
        end
        OFF_STATUS: begin
          rdata[31]     = ovf_q;
          rdata[17]     = full;
          rdata[16]     = empty;
          rdata[CW-1:0] = count_q;
        end
        default: ;
      endcase
    end
  end

  assign bus.pReady_o    = ~stall;
  assign bus.pDataRead_o = rdata;
  assign bus.pSlvErr_o   = err;

  // staging registers and sticky overflow
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      opcode_q <= '0;
      x1_q     <= '0;
      y1_q     <= '0;
      x2_q     <= '0;
      y2_q     <= '0;
      r_q      <= '0;
      g_q      <= '0;
      b_q      <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (wr_en && hit_w0) begin
        opcode_q <= bus.pDataWrite_i[31:28];
        y1_q     <= bus.pDataWrite_i[HEIGHT_BITS+15:16];
        x1_q     <= bus.pDataWrite_i[WIDTH_BITS-1:0];
      end
      if (wr_en && hit_w1) begin
        y2_q <= bus.pDataWrite_i[HEIGHT_BITS+15:16];
        x2_q <= bus.pDataWrite_i[WIDTH_BITS-1:0];
      end
      if (wr_en && hit_w2) begin
        b_q <= bus.pDataWrite_i[CHANNEL_BITS+15:16];
        g_q <= bus.pDataWrite_i[CHANNEL_BITS+7:8];
        r_q <= bus.pDataWrite_i[CHANNEL_BITS-1:0];
      end
      // set wins over clear
      if (drop)
        ovf_q <= 1'b1;
      else if (ovf_clr)
        ovf_q <= 1'b0;
    end
  end

  // FIFO pointers and occupancy; flush overrides any push/pop on the same edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else if (flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      count_q <= count_q + CW'(push) - CW'(pop);
    end
  end

  // storage needs no reset: entries are only visible while counted
  always_ff @(posedge clk) begin
    if (push && !flush)
      mem[wr_ptr] <= stage;
  end

  assign head = mem[rd_ptr];

  assign bus.cmd_valid_o = ~empty;
  assign bus.opcode_o    = empty ? '0 : head.opcode;
  assign bus.x1_o        = empty ? '0 : head.x1;
  assign bus.y1_o        = empty ? '0 : head.y1;
  assign bus.x2_o        = empty ? '0 : head.x2;
  assign bus.y2_o        = empty ? '0 : head.y2;
  assign bus.r_o         = empty ? '0 : head.r;
  assign bus.g_o         = empty ? '0 : head.g;
  assign bus.b_o         = empty ? '0 : head.b;
  assign bus.count_o     = count_q;

  logic unused_ok;
  assign unused_ok = ^{bus.pAddr_i[31:8], bus.pDataWrite_i};

endmodule
